// File: rtl/wb_write_queue.sv
// Writeback queue feeding the dual-write-port register file: buffers up to two
// results per cycle, drains up to two per cycle, and forwards pending values.
module wb_write_queue #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid1,
  input  logic [4:0]      in_rd1,
  input  logic [XLEN-1:0] in_data1,
  input  logic            in_valid2,
  input  logic [4:0]      in_rd2,
  input  logic [XLEN-1:0] in_data2,
  output logic            in_ready,
  input  logic            drain_en,
  output logic            Wen1,
  output logic [4:0]      Rd_addr1,
  output logic [XLEN-1:0] write_data1,
  output logic            Wen2,
  output logic [4:0]      Rd_addr2,
  output logic [XLEN-1:0] write_data2,
  input  logic [4:0]      lk_addr1,
  input  logic [4:0]      lk_addr2,
  output logic            lk_hit1,
  output logic            lk_hit2,
  output logic [XLEN-1:0] lk_data1,
  output logic [XLEN-1:0] lk_data2,
  output logic [CW-1:0]   count,
  output logic            empty
);

  localparam int PW = $clog2(DEPTH);

  logic [4:0]      r_q_rd   [DEPTH];
  logic [XLEN-1:0] r_q_data [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic            w_acc1;
  logic            w_acc2;
  logic [1:0]      w_enq;
  logic [1:0]      w_deq;
  logic [PW-1:0]   w_wr_idx2;
  logic [PW-1:0]   w_rd_idx2;
  logic            w_waw;

  // Readiness uses only the registered count, so a same-cycle pop never opens space.
  assign in_ready  = (r_count <= CW'(DEPTH - 2));
  assign count     = r_count;
  assign empty     = (r_count == '0);

  assign w_acc1    = in_ready && in_valid1 && (in_rd1 != 5'd0);
  assign w_acc2    = in_ready && in_valid2 && (in_rd2 != 5'd0);
  assign w_enq     = {1'b0, w_acc1} + {1'b0, w_acc2};
  assign w_deq     = !drain_en ? 2'd0 :
                     (r_count >= CW'(2)) ? 2'd2 : r_count[1:0];
  assign w_wr_idx2 = r_wr_ptr + PW'(w_acc1);
  assign w_rd_idx2 = r_rd_ptr + PW'(1);
  assign w_waw     = (r_q_rd[r_rd_ptr] == r_q_rd[w_rd_idx2]);

  // Entry storage needs no reset: validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_acc1) begin
      r_q_rd[r_wr_ptr]   <= in_rd1;
      r_q_data[r_wr_ptr] <= in_data1;
    end
    if (w_acc2) begin
      r_q_rd[w_wr_idx2]   <= in_rd2;
      r_q_data[w_wr_idx2] <= in_data2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      Wen1        <= 1'b0;
      Wen2        <= 1'b0;
      Rd_addr1    <= 5'd0;
      Rd_addr2    <= 5'd0;
      write_data1 <= '0;
      write_data2 <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(w_enq);
      r_rd_ptr <= r_rd_ptr + PW'(w_deq);
      r_count  <= r_count + CW'(w_enq) - CW'(w_deq);
      // An older write to the same register in the same pop is redundant.
      Wen1     <= (w_deq != 2'd0) && !((w_deq == 2'd2) && w_waw);
      Wen2     <= (w_deq == 2'd2);
      if (w_deq != 2'd0) begin
        Rd_addr1    <= r_q_rd[r_rd_ptr];
        write_data1 <= r_q_data[r_rd_ptr];
      end
      if (w_deq == 2'd2) begin
        Rd_addr2    <= r_q_rd[w_rd_idx2];
        write_data2 <= r_q_data[w_rd_idx2];
      end
    end
  end

  // Scan oldest to youngest so the last match (youngest) wins.
  function automatic logic [XLEN:0] lookup(input logic [4:0] addr);
    logic            hit;
    logic [XLEN-1:0] data;
    logic [PW-1:0]   idx;
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    if (addr != 5'd0) begin
      if (Wen1 && (Rd_addr1 == addr)) begin
        hit  = 1'b1;
        data = write_data1;
      end
      if (Wen2 && (Rd_addr2 == addr)) begin
        hit  = 1'b1;
        data = write_data2;
      end
      for (int k = 0; k < DEPTH; k++) begin
        idx = r_rd_ptr + PW'(k);
        if ((CW'(k) < r_count) && (r_q_rd[idx] == addr)) begin
          hit  = 1'b1;
          data = r_q_data[idx];
        end
      end
    end
    return {hit, data};
  endfunction

  always_comb begin
    {lk_hit1, lk_data1} = lookup(lk_addr1);
    {lk_hit2, lk_data2} = lookup(lk_addr2);
  end

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue: a negedge monitor checks every register
// file write against an expected queue; direct checks cover state and lookup.
module tb_wb_write_queue;

  localparam int XLEN = 64;
  localparam int DEPTH = 8;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int W = 2 + 5 + XLEN + 5 + XLEN;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid1 = 1'b0;
  logic [4:0]      in_rd1 = '0;
  logic [XLEN-1:0] in_data1 = '0;
  logic            in_valid2 = 1'b0;
  logic [4:0]      in_rd2 = '0;
  logic [XLEN-1:0] in_data2 = '0;
  logic            in_ready;
  logic            drain_en = 1'b0;
  logic            Wen1, Wen2;
  logic [4:0]      Rd_addr1, Rd_addr2;
  logic [XLEN-1:0] write_data1, write_data2;
  logic [4:0]      lk_addr1 = '0;
  logic [4:0]      lk_addr2 = '0;
  logic            lk_hit1, lk_hit2;
  logic [XLEN-1:0] lk_data1, lk_data2;
  logic [CW-1:0]   count;
  logic            empty;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  wb_write_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid1(in_valid1), .in_rd1(in_rd1), .in_data1(in_data1),
    .in_valid2(in_valid2), .in_rd2(in_rd2), .in_data2(in_data2),
    .in_ready(in_ready), .drain_en(drain_en),
    .Wen1(Wen1), .Rd_addr1(Rd_addr1), .write_data1(write_data1),
    .Wen2(Wen2), .Rd_addr2(Rd_addr2), .write_data2(write_data2),
    .lk_addr1(lk_addr1), .lk_addr2(lk_addr2),
    .lk_hit1(lk_hit1), .lk_hit2(lk_hit2),
    .lk_data1(lk_data1), .lk_data2(lk_data2),
    .count(count), .empty(empty)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Disabled ports are masked so only enabled writes are compared.
  function automatic logic [W-1:0] rec(input logic w1, input logic w2,
                                       input logic [4:0] a1, input logic [XLEN-1:0] d1,
                                       input logic [4:0] a2, input logic [XLEN-1:0] d2);
    return {w1, w2, w1 ? a1 : 5'd0, w1 ? d1 : {XLEN{1'b0}},
            w2 ? a2 : 5'd0, w2 ? d2 : {XLEN{1'b0}}};
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] act;
    logic [W-1:0] e;
    if (!rst && (Wen1 || Wen2)) begin
      act = rec(Wen1, Wen2, Rd_addr1, write_data1, Rd_addr2, write_data2);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write got=%h want=no write", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          n_bad++;
          $display("FAIL port_write got=%h want=%h", act, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic v1, input logic [4:0] r1, input logic [XLEN-1:0] d1,
                      input logic v2, input logic [4:0] r2, input logic [XLEN-1:0] d2);
    in_valid1 = v1; in_rd1 = r1; in_data1 = d1;
    in_valid2 = v2; in_rd2 = r2; in_data2 = d2;
    tick(1);
    in_valid1 = 1'b0;
    in_valid2 = 1'b0;
  endtask

  initial begin
    #12;
    check("rst_wen1", Wen1, 0);
    check("rst_wen2", Wen2, 0);
    check("rst_rd_addr1", Rd_addr1, 0);
    check("rst_data2", write_data2, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    tick(1);

    // Single write with drain enabled
    drain_en = 1'b1;
    exp_q.push_back(rec(1, 0, 5, 64'h1234, 0, 0));
    send(1, 5, 64'h1234, 0, 0, 0);
    check("single_count_n", count, 1);
    check("single_wen1_n", Wen1, 0);
    lk_addr2 = 5;
    tick(1);
    check("single_count_n1", count, 0);
    check("lk_port1_hit", lk_hit2, 1);
    check("lk_port1_data", lk_data2, 64'h1234);
    tick(1);
    check("single_wen1_n2", Wen1, 0);
    lk_addr2 = 0;

    // x0 drop
    exp_q.push_back(rec(1, 0, 3, 64'h7, 0, 0));
    send(1, 0, 64'hFF, 1, 3, 64'h7);
    check("x0_count", count, 1);
    lk_addr1 = 3;
    #1;
    check("lk_queue_hit", lk_hit1, 1);
    check("lk_queue_data", lk_data1, 64'h7);
    lk_addr1 = 0;
    tick(2);
    check("x0_drained", count, 0);

    // WAW pair in one pop
    exp_q.push_back(rec(0, 1, 9, 64'hA, 9, 64'hB));
    send(1, 9, 64'hA, 1, 9, 64'hB);
    check("waw_count", count, 2);
    tick(1);
    check("waw_wen1", Wen1, 0);
    check("waw_wen2", Wen2, 1);
    check("waw_rd_addr1", Rd_addr1, 9);
    check("waw_data1", write_data1, 64'hA);
    tick(1);

    // Fill to full, reject a fifth pair, then drain
    drain_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(rec(1, 1, 5'(2*i+1), 64'h100 + 64'(2*i+1),
                          5'(2*i+2), 64'h100 + 64'(2*i+2)));
      send(1, 5'(2*i+1), 64'h100 + 64'(2*i+1), 1, 5'(2*i+2), 64'h100 + 64'(2*i+2));
    end
    check("full_count", count, 8);
    check("full_in_ready", in_ready, 0);
    send(1, 20, 64'hDEAD, 1, 21, 64'hBEEF);
    check("full_ignored_count", count, 8);
    lk_addr1 = 20;
    lk_addr2 = 8;
    #1;
    check("full_ignored_lk", lk_hit1, 0);
    check("full_lk_hit", lk_hit2, 1);
    check("full_lk_data", lk_data2, 64'h108);
    lk_addr1 = 0;
    lk_addr2 = 0;
    drain_en = 1'b1;
    tick(1);
    check("drain1_count", count, 6);
    check("drain1_in_ready", in_ready, 1);
    tick(3);
    check("drained_count", count, 0);
    check("drained_empty", empty, 1);
    tick(1);
    check("drained_wen1", Wen1, 0);

    // Forwarding across queue and output stage
    drain_en = 1'b0;
    send(1, 7, 64'h11, 1, 7, 64'h22);
    lk_addr1 = 7;
    lk_addr2 = 0;
    #1;
    check("fwd_hit1", lk_hit1, 1);
    check("fwd_data1", lk_data1, 64'h22);
    check("fwd_hit2_x0", lk_hit2, 0);
    check("fwd_data2_x0", lk_data2, 0);
    exp_q.push_back(rec(0, 1, 7, 64'h11, 7, 64'h22));
    drain_en = 1'b1;
    tick(1);
    drain_en = 1'b0;
    check("fwd_out_wen1", Wen1, 0);
    check("fwd_out_hit", lk_hit1, 1);
    check("fwd_out_data", lk_data1, 64'h22);
    lk_addr1 = 0;
    tick(2);

    // Reset mid-operation
    send(1, 10, 64'hA0, 1, 11, 64'hA1);
    send(1, 12, 64'hA2, 1, 13, 64'hA3);
    send(1, 14, 64'hA4, 0, 0, 0);
    check("mid_count", count, 5);
    exp_q.push_back(rec(1, 1, 10, 64'hA0, 11, 64'hA1));
    drain_en = 1'b1;
    tick(1);
    check("mid_wen1", Wen1, 1);
    check("mid_count_after_pop", count, 3);
    @(negedge clk);
    #1;
    rst = 1'b1;
    lk_addr1 = 14;
    #1;
    check("mid_rst_wen1", Wen1, 0);
    check("mid_rst_wen2", Wen2, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_lk", lk_hit1, 0);
    #1;
    rst = 1'b0;
    lk_addr1 = 0;
    tick(4);
    check("post_rst_count", count, 0);

    tick(2);
    check("exp_q_drained", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
